serializer: RTL and testbench
=============================

// Module: serializer
//
// PURPOSE
//  Transmit side of the serial link: accepts one 1..10-bit word with a length and
//  sends it as a frame: 4-bit preamble, data bits MSB first, then one even-parity bit.
//  ser_data_en_o is high for exactly the frame bits. Sits in front of the link deserializer.
//  Enforces the idle gap that the deserializer needs between frames.
//
// PARAMETERS
//  PREAMB      4'b1010  preamble bits, sent PREAMB[3] first
//  GAP_CYCLES  2        idle cycles (en low) after each frame; minimum 2, smaller values behave as 2
//
// PORTS
//  clk_i          in   1   clock
//  rst_i          in   1   synchronous active-high reset
//  data_i         in   10  payload; only bits [len-1:0] are sent
//  data_len_i     in   4   payload length N; 1..10 valid, 0 or >10 treated as 10
//  data_val_i     in   1   payload valid
//  data_rdy_o     out  1   ready to accept; transfer on data_val_i && data_rdy_o at clk edge
//  ser_data_o     out  1   serial bit, 0 when ser_data_en_o low
//  ser_data_en_o  out  1   serial bit valid
//  busy_o         out  1   frame or gap in progress (= !data_rdy_o)
//
// BEHAVIOUR
//  - Reset: state IDLE_S, ser_data_o=0, ser_data_en_o=0, data_rdy_o=1, busy_o=0; internal regs cleared.
//  - Handshake: data_rdy_o=1 only in IDLE_S (decoded from state). On accept, data_i, effective N and
//    parity are latched. Inputs are ignored while busy.
//  - Latency: accept at edge k -> first preamble bit on ser outputs from edge k (registered, visible
//    in the cycle after the handshake cycle).
//  - Frame: 4 preamble bits, then data_i[N-1] .. data_i[0], then parity = ^data_i[N-1:0];
//    total 5+N cycles of ser_data_en_o=1, with no bubbles.
//  - States:
//    - IDLE_S -> PREAMB_S on accept.
//    - PREAMB_S: 4 cycles -> DATA_S.
//    - DATA_S: N cycles, down-counting bit index -> PARITY_S.
//    - PARITY_S: 1 cycle -> GAP_S.
//    - GAP_S: GAP_CYCLES cycles with en=0 -> IDLE_S.
//  - Back-to-back: with data_val_i held high, the next frame's first bit starts GAP_CYCLES+1 cycles
//    after the previous parity bit (GAP_CYCLES gap cycles + 1 IDLE_S handshake cycle).
//  - Length: 4-bit N compared unsigned; N outside 1..10 forced to 10 at latch time, never mid-frame.
//  - Reset mid-frame: next edge forces reset values; the frame is truncated and no gap is inserted;
//    data_rdy_o=1 the cycle after rst_i drops.
//  - rst_i and data_val_i high together: reset wins, no transfer.
//
// CONFIGURATION
//  SERIALIZER_ERR_INJECT_EN defined:
//    - adds input port err_inj_i (1 bit), latched at accept;
//    - when latched 1, the sent parity bit is inverted and PREAMB[0] is inverted;
//    - drives the receiver's parity and preamble error paths.
//  Not defined: port absent, frames always well-formed.
//
// TESTING
//  1. data_i=10'b1010100101, len=10 -> en 15 cycles; bits 1010_1010100101_1.
//  2. data_i=10'b1111111101, len=3 -> en 8 cycles; bits 1010_101_0; upper data bits not sent.
//  3. len=0 and len=15, data_i=10'h3FF -> both send 10 ones, parity 0, en 15 cycles.
//  4. data_val_i held high, 3 words, len=4 -> frames of 9 en cycles separated by exactly 3
//     en-low cycles (GAP_CYCLES=2).
//  5. rst_i pulsed 1 cycle on 6th frame bit -> en=0 next cycle, rdy=1 after release; a following
//     word is sent as a complete, correct frame.
//  6. SERIALIZER_ERR_INJECT_EN, data_i=10'h001, len=10, err_inj_i=1 -> bits 1011_0000000001_0;
//     paired deserializer asserts err_o.

Source files
------------

// File: rtl/serializer.sv
// Frame serializer: preamble, payload MSB first, even parity, idle gap.
// Optional macro SERIALIZER_ERR_INJECT_EN adds err_inj_i for corrupt frames.
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   data_i         payload, bits [N-1:0] are sent
//   data_len_i     payload length N (0 or >10 means 10)
//   data_val_i     payload valid
//   data_rdy_o     ready to accept (IDLE_S only)
//   ser_data_o     serial bit, 0 when ser_data_en_o is low
//   ser_data_en_o  serial bit valid
//   busy_o         frame or gap in progress
//   err_inj_i      (macro only) invert parity and last preamble bit
module serializer #(
  parameter logic [3:0] PREAMB     = 4'b1010,
  parameter int         GAP_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] data_i,
  input  logic [3:0] data_len_i,
  input  logic       data_val_i,
`ifdef SERIALIZER_ERR_INJECT_EN
  input  logic       err_inj_i,
`endif
  output logic       data_rdy_o,
  output logic       ser_data_o,
  output logic       ser_data_en_o,
  output logic       busy_o
);

  localparam int GAP_EFF = (GAP_CYCLES < 2) ? 2 : GAP_CYCLES;
  localparam int CW =
    ($clog2(GAP_EFF) > 4) ? $clog2(GAP_EFF) : 4;

  typedef enum logic [2:0] {
    IDLE_S,
    PREAMB_S,
    DATA_S,
    PARITY_S,
    GAP_S
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [9:0]    r_data;
  logic [3:0]    r_len;
  logic          r_par;
  logic          r_err;

  logic          w_acc;
  logic [3:0]    w_len;
  logic [9:0]    w_mask;
  logic          w_par;
  logic          w_err;

`ifdef SERIALIZER_ERR_INJECT_EN
  assign w_err = err_inj_i;
`else
  assign w_err = 1'b0;
`endif

  assign w_acc      = data_val_i && (r_state == IDLE_S);
  assign data_rdy_o = (r_state == IDLE_S);
  assign busy_o     = !data_rdy_o;

  // Out-of-range lengths collapse to a full word.
  always_comb begin
    w_len = data_len_i;
    if (data_len_i == 4'd0 || data_len_i > 4'd10) begin
      w_len = 4'd10;
    end
  end

  assign w_mask = 10'((11'd1 << w_len) - 11'd1);
  assign w_par  = ^(data_i & w_mask);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE_S;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE_S: begin
        if (data_val_i) begin
          w_state_nxt = PREAMB_S;
          w_cnt_nxt   = CW'(3);
        end
      end
      PREAMB_S: begin
        if (r_cnt == '0) begin
          w_state_nxt = DATA_S;
          w_cnt_nxt   = CW'(r_len - 4'd1);
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      DATA_S: begin
        if (r_cnt == '0) begin
          w_state_nxt = PARITY_S;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      PARITY_S: begin
        w_state_nxt = GAP_S;
        w_cnt_nxt   = CW'(GAP_EFF - 1);
      end
      GAP_S: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE_S;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE_S;
      end
    endcase
  end

  // Outputs decode straight from registered state, so the first
  // preamble bit appears right after the accepting edge.
  always_comb begin
    ser_data_o    = 1'b0;
    ser_data_en_o = 1'b0;
    unique case (r_state)
      PREAMB_S: begin
        ser_data_en_o = 1'b1;
        ser_data_o    = PREAMB[r_cnt[1:0]]
                      ^ (r_err && (r_cnt[1:0] == 2'd0));
      end
      DATA_S: begin
        ser_data_en_o = 1'b1;
        ser_data_o    = r_data[r_cnt[3:0]];
      end
      PARITY_S: begin
        ser_data_en_o = 1'b1;
        ser_data_o    = r_par ^ r_err;
      end
      default: begin
        ser_data_en_o = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt  <= '0;
      r_data <= '0;
      r_len  <= '0;
      r_par  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_acc) begin
        r_data <= data_i;
        r_len  <= w_len;
        r_par  <= w_par;
        r_err  <= w_err;
      end
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Bench for serializer: random and directed words vs a frame model.
// Monitor rebuilds frames from the serial pins and compares at the end.
module tb_serializer;

  localparam logic [3:0] PRE = 4'b1010;
`ifdef SERIALIZER_ERR_INJECT_EN
  localparam bit HAS_EI = 1'b1;
`else
  localparam bit HAS_EI = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_i;
  logic [9:0] data_i;
  logic [3:0] data_len_i;
  logic       data_val_i;
  logic       err_inj;
  logic       data_rdy_o;
  logic       ser_data_o;
  logic       ser_data_en_o;
  logic       busy_o;

  always #5 clk = ~clk;

  serializer dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .data_i        (data_i),
    .data_len_i    (data_len_i),
    .data_val_i    (data_val_i),
`ifdef SERIALIZER_ERR_INJECT_EN
    .err_inj_i     (err_inj),
`endif
    .data_rdy_o    (data_rdy_o),
    .ser_data_o    (ser_data_o),
    .ser_data_en_o (ser_data_en_o),
    .busy_o        (busy_o)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  int exp_v[$];
  int exp_n[$];
  int exp_g[$];
  int mon_v[$];
  int mon_n[$];
  int mon_g[$];

  // Frame as an integer whose MSB is the first bit on the wire.
  function automatic void model(input logic [9:0] d,
                                input logic [3:0] l,
                                input bit ei,
                                output int v,
                                output int n);
    int nn;
    int par;
    nn = (l < 1 || l > 10) ? 10 : int'(l);
    v = int'(PRE) ^ (ei ? 1 : 0);
    par = 0;
    for (int i = nn - 1; i >= 0; i--) begin
      v = v * 2 + int'(d[i]);
      par = par ^ int'(d[i]);
    end
    par = par ^ (ei ? 1 : 0);
    v = v * 2 + par;
    n = nn + 5;
  endfunction

  bit mon_on = 1'b0;
  bit m_in = 1'b0;
  int m_v = 0;
  int m_n = 0;
  int m_low = 0;

  always @(negedge clk) begin
    if (mon_on) begin
      if (ser_data_en_o === 1'b1) begin
        if (!m_in) begin
          m_in = 1'b1;
          m_v = 0;
          m_n = 0;
          mon_g.push_back(m_low);
        end
        m_v = m_v * 2 + ((ser_data_o === 1'b1) ? 1 : 0);
        m_n++;
        m_low = 0;
      end else begin
        check("idle_bit_zero", ser_data_o, 0);
        if (m_in) begin
          mon_v.push_back(m_v);
          mon_n.push_back(m_n);
          m_in = 1'b0;
        end
        m_low++;
      end
    end
  end

  task automatic send(input logic [9:0] d,
                      input logic [3:0] l,
                      input bit ei,
                      input int g,
                      input bit hold);
    bit ok;
    bit eie;
    int v;
    int n;
    ok = 1'b0;
    eie = ei && HAS_EI;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (data_rdy_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("rdy_timeout", 0, 1);
      return;
    end
    data_i = d;
    data_len_i = l;
    err_inj = eie;
    data_val_i = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) data_val_i = 1'b0;
    model(d, l, eie, v, n);
    exp_v.push_back(v);
    exp_n.push_back(n);
    exp_g.push_back(g);
    check("lat_en", ser_data_en_o, 1);
    check("lat_bit", ser_data_o, PRE[3]);
    check("busy", busy_o, 1);
    check("rdy_low", data_rdy_o, 0);
  endtask

  initial begin
    int v;
    int n;
    bit prev_hold;
    bit h;
    rst_i = 1'b1;
    data_i = '0;
    data_len_i = '0;
    data_val_i = 1'b0;
    err_inj = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rdy", data_rdy_o, 1);
    check("rst_en", ser_data_en_o, 0);
    check("rst_ser", ser_data_o, 0);
    check("rst_busy", busy_o, 0);
    rst_i = 1'b0;
    mon_on = 1'b1;

    send(10'b1010100101, 4'd10, 1'b0, -1, 1'b0);
    send(10'b1111111101, 4'd3, 1'b0, -1, 1'b0);
    send(10'h3FF, 4'd0, 1'b0, -1, 1'b0);
    send(10'h3FF, 4'd15, 1'b0, -1, 1'b0);

    send(10'h00A, 4'd4, 1'b0, -1, 1'b1);
    send(10'h005, 4'd4, 1'b0, 3, 1'b1);
    send(10'h00F, 4'd4, 1'b0, 3, 1'b1);
    data_val_i = 1'b0;

    send(10'h2B7, 4'd10, 1'b0, -1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("rst6_en_before", ser_data_en_o, 1);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    check("rst6_en", ser_data_en_o, 0);
    check("rst6_rdy", data_rdy_o, 1);
    check("rst6_busy", busy_o, 0);
    rst_i = 1'b0;
    @(negedge clk);
    check("rst6_rdy_rel", data_rdy_o, 1);
    v = exp_v.pop_back();
    n = exp_n.pop_back();
    exp_v.push_back(v >> (n - 6));
    exp_n.push_back(6);
    send(10'h19C, 4'd7, 1'b0, -1, 1'b0);

    repeat (25) @(negedge clk);
    rst_i = 1'b1;
    data_val_i = 1'b1;
    data_i = 10'h155;
    data_len_i = 4'd5;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    data_val_i = 1'b0;
    @(negedge clk);
    check("rstval_en", ser_data_en_o, 0);
    check("rstval_rdy", data_rdy_o, 1);

`ifdef SERIALIZER_ERR_INJECT_EN
    send(10'h001, 4'd10, 1'b1, -1, 1'b0);
`endif

    prev_hold = 1'b0;
    for (int k = 0; k < 30; k++) begin
      h = ($urandom_range(0, 1) == 1);
      send(10'($urandom), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0), prev_hold ? 3 : -1, h);
      if (!h) repeat ($urandom_range(0, 20)) @(negedge clk);
      prev_hold = h;
    end
    data_val_i = 1'b0;

    repeat (40) @(negedge clk);
    check("nframes", mon_v.size(), exp_v.size());
    for (int i = 0; i < exp_v.size() && i < mon_v.size(); i++) begin
      check($sformatf("frame%0d_bits", i), mon_v[i], exp_v[i]);
      check($sformatf("frame%0d_len", i), mon_n[i], exp_n[i]);
      if (exp_g[i] >= 0) begin
        check($sformatf("frame%0d_gap", i), mon_g[i], exp_g[i]);
      end
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
